// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: opcodes, regfile/memory write
// select, FSM states and access sizes, plus small opcode decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_SDW  = 3'b000,
        OP_SDH  = 3'b001,
        OP_SDB  = 3'b010,
        OP_LDW  = 3'b011,
        OP_LDH  = 3'b100,
        OP_LDB  = 3'b101,
        OP_ILL  = 3'b110,
        OP_LDBU = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        WW_NONE = 2'b00,
        WW_REG  = 2'b01,
        WW_MEM  = 2'b10
    } ww_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WB   = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    function automatic logic is_store(input op_e op);
        return (op == OP_SDW) || (op == OP_SDH) || (op == OP_SDB);
    endfunction

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_SDW, OP_LDW: return SZ_W;
            OP_SDH, OP_LDH: return SZ_H;
            default:        return SZ_B;
        endcase
    endfunction

    // Bytes are never misaligned; halfwords need bit 0 clear, words bits 1:0.
    function automatic logic misaligned(input op_e op, input logic [1:0] a);
        case (op_size(op))
            SZ_W:    return a != 2'b00;
            SZ_H:    return a[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes and lane-replicated write data, and
// load-data extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int LANE_W = $clog2(NB)
) (
    input  op_e              i_op,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [XLEN-1:0]  i_xs,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [NB-1:0]    o_wstrb,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_load
);

    size_e             w_size;
    logic [NB-1:0]     w_mask;
    logic [XLEN-1:0]   w_shift;

    assign w_size  = op_size(i_op);
    assign w_mask  = (w_size == SZ_W) ? NB'(4'hF) :
                     (w_size == SZ_H) ? NB'(2'h3) : NB'(1'b1);
    assign o_wstrb = w_mask << i_lane;
    assign w_shift = i_rdata >> {i_lane, 3'b000};

    // Every byte lane gets the matching byte of the source word/half/byte.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign o_wdata[gi*8 +: 8] = (w_size == SZ_W) ? i_xs[(gi % 4)*8 +: 8] :
                                        (w_size == SZ_H) ? i_xs[(gi % 2)*8 +: 8] :
                                                           i_xs[7:0];
        end
    endgenerate

    always_comb begin
        o_load = '0;
        case (i_op)
            OP_LDW:  o_load = XLEN'($signed(w_shift[31:0]));
            OP_LDH:  o_load = XLEN'($signed(w_shift[15:0]));
            OP_LDB:  o_load = XLEN'($signed(w_shift[7:0]));
            OP_LDBU: o_load = XLEN'(w_shift[7:0]);
            default: o_load = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: address generation, alignment check,
// memory handshake with timeout, and regfile write-back.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 21,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        opcode,
    input  logic [XLEN-1:0]   xs,
    input  logic [XLEN-1:0]   xd,
    input  logic [IMM_W-1:0]  imm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic [XLEN-1:0]   y,
    output logic [1:0]        write_which,
    output logic              done,
    output logic              err
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    state_e            r_state, w_state_next;
    op_e               r_op, w_op;
    logic [XLEN-1:0]   r_addr, r_xs, r_y;
    logic [CNT_W-1:0]  r_wait;
    logic              r_done, r_err;
    logic              w_fin_err;
    logic [XLEN-1:0]   w_addr, w_base, w_load;
    logic [NB-1:0]     w_wstrb;
    logic              w_store;

    assign w_op    = op_e'(opcode);
    assign w_base  = is_store(w_op) ? xd : xs;
    assign w_addr  = w_base + XLEN'($signed(imm));
    assign w_store = is_store(r_op);

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .i_op    (r_op),
        .i_lane  (r_addr[LANE_W-1:0]),
        .i_xs    (r_xs),
        .i_rdata (mem_rdata),
        .o_wstrb (w_wstrb),
        .o_wdata (mem_wdata),
        .o_load  (w_load)
    );

    // Dropping en in REQ/WB aborts silently and takes priority over mem_ack.
    always_comb begin
        w_state_next = r_state;
        w_fin_err    = 1'b0;
        case (r_state)
            ST_IDLE: if (en) begin
                if (w_op == OP_ILL || misaligned(w_op, w_addr[1:0])) begin
                    w_state_next = ST_FIN;
                    w_fin_err    = 1'b1;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                end else if (mem_ack) begin
                    w_state_next = w_store ? ST_FIN : ST_WB;
                end else if (r_wait == CNT_W'(TIMEOUT - 1)) begin
                    w_state_next = ST_FIN;
                    w_fin_err    = 1'b1;
                end
            end
            ST_WB:   w_state_next = en ? ST_FIN : ST_IDLE;
            ST_FIN:  if (!en) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_SDW;
            r_addr  <= '0;
            r_xs    <= '0;
            r_y     <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == ST_FIN) && (r_state != ST_FIN);
            r_err   <= w_fin_err;
            r_wait  <= (r_state == ST_REQ && !mem_ack) ? r_wait + CNT_W'(1) : '0;
            if (r_state == ST_IDLE && en) begin
                r_op   <= w_op;
                r_addr <= w_addr;
                r_xs   <= xs;
            end
            if (r_state == ST_REQ && en && mem_ack && !w_store) begin
                r_y <= w_load;
            end
        end
    end

    assign mem_req   = (r_state == ST_REQ);
    assign mem_we    = mem_req && w_store;
    assign mem_wstrb = mem_we ? w_wstrb : '0;
    assign mem_addr  = r_addr;
    assign y         = r_y;
    assign done      = r_done;
    assign err       = r_err;

    always_comb begin
        write_which = WW_NONE;
        if (r_state == ST_REQ && en && mem_ack && w_store) write_which = WW_MEM;
        else if (r_state == ST_WB && en)                   write_which = WW_REG;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single transactions on a
// 32-bit instance, then timeout/abort/reset sequences and a 64-bit instance.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, mem_req, mem_we, mem_ack, done, err;
    logic [2:0]  opcode;
    logic [31:0] xs, xd, mem_addr, mem_wdata, mem_rdata, y;
    logic [20:0] imm;
    logic [3:0]  mem_wstrb;
    logic [1:0]  write_which;

    logic        en64, mem_req64, mem_we64, done64, err64;
    logic [2:0]  opcode64;
    logic [63:0] xs64, xd64, mem_addr64, mem_wdata64, mem_rdata64, y64;
    logic [20:0] imm64;
    logic [7:0]  mem_wstrb64;
    logic [1:0]  ww64;

    logic ack_on;
    int   ack_delay;
    int   req_cnt;

    always @(posedge clk) begin
        if (rst || !mem_req) req_cnt <= 0;
        else                 req_cnt <= req_cnt + 1;
    end
    assign mem_ack = ack_on && mem_req && (req_cnt >= ack_delay);

    load_store_unit #(.XLEN(32), .IMM_W(21), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .xs(xs), .xd(xd), .imm(imm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .y(y),
        .write_which(write_which), .done(done), .err(err)
    );

    load_store_unit #(.XLEN(64), .IMM_W(21), .TIMEOUT(15)) dut64 (
        .clk(clk), .rst(rst), .en(en64), .opcode(opcode64), .xs(xs64), .xd(xd64), .imm(imm64),
        .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
        .mem_wstrb(mem_wstrb64), .mem_rdata(mem_rdata64), .mem_ack(mem_req64), .y(y64),
        .write_which(ww64), .done(done64), .err(err64)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] xs, xd;
        logic [20:0] imm;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_y;
        logic [1:0]  exp_ww;
        int          exp_done;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [2:0] op, input logic [31:0] vxs,
                                input logic [31:0] vxd, input logic [20:0] vimm, input logic [31:0] rd,
                                input logic e, input logic [31:0] a, input logic [3:0] s,
                                input logic [31:0] wd, input logic [31:0] vy, input logic [1:0] ww,
                                input int dc);
        vec_t v;
        v.name = name; v.op = op; v.xs = vxs; v.xd = vxd; v.imm = vimm; v.rdata = rd;
        v.exp_err = e; v.exp_addr = a; v.exp_wstrb = s; v.exp_wdata = wd; v.exp_y = vy;
        v.exp_ww = ww; v.exp_done = dc;
        return v;
    endfunction

    // Runs one transaction; records what the memory side and result side showed.
    task automatic run_op(input vec_t v, input int delay);
        logic        req_seen, we_s, stable_ok;
        logic [31:0] addr_s, wdata_s, y_wb;
        logic [3:0]  wstrb_s;
        logic [1:0]  ww_or;
        int          done_cyc, n_done, n_err;
        req_seen = 0; we_s = 0; stable_ok = 1; addr_s = 0; wdata_s = 0; y_wb = 0;
        wstrb_s = 0; ww_or = 0; done_cyc = -1; n_done = 0; n_err = 0;
        @(negedge clk);
        opcode = v.op; xs = v.xs; xd = v.xd; imm = v.imm; mem_rdata = v.rdata;
        ack_delay = delay; ack_on = 1'b1; en = 1'b1;
        for (int c = 1; c <= delay + 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (mem_req) begin
                if (!req_seen) begin
                    addr_s = mem_addr; wdata_s = mem_wdata; wstrb_s = mem_wstrb; we_s = mem_we;
                end else if (mem_addr !== addr_s || mem_wstrb !== wstrb_s || mem_we !== we_s) begin
                    stable_ok = 0;
                end
                req_seen = 1;
            end
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (err) n_err++;
            ww_or = ww_or | write_which;
            if (write_which == 2'b01) y_wb = y;
        end
        en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({v.name, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done + (v.exp_err ? 0 : delay)));
        chk({v.name, " done_pulses"}, 64'(n_done), 64'd1);
        chk({v.name, " err_pulses"}, 64'(n_err), 64'(v.exp_err));
        chk({v.name, " write_which"}, 64'(ww_or), 64'(v.exp_ww));
        chk({v.name, " mem_req_seen"}, 64'(req_seen), 64'(!v.exp_err));
        if (!v.exp_err) begin
            chk({v.name, " mem_addr"}, 64'(addr_s), 64'(v.exp_addr));
            chk({v.name, " mem_wstrb"}, 64'(wstrb_s), 64'(v.exp_wstrb));
            chk({v.name, " req_stable"}, 64'(stable_ok), 64'd1);
            if (v.exp_ww == 2'b10) chk({v.name, " mem_wdata"}, 64'(wdata_s), 64'(v.exp_wdata));
            else                   chk({v.name, " y"}, 64'(y_wb), 64'(v.exp_y));
        end
        $display("txn %s op=%0d addr=%0h done_cyc=%0d err=%0d", v.name, v.op, addr_s, done_cyc, n_err);
    endtask

    vec_t vecs[15];
    int   req_hi, done_cyc, n_done, n_err;
    logic [1:0] ww_or;

    initial begin
        vecs[0]  = mk("LDW_104",   3'd3, 32'h100, 32'h0,    21'h4,      32'hDEADBEEF, 0, 32'h104,      4'h0, 32'h0,        32'hDEADBEEF, 2'b01, 3);
        vecs[1]  = mk("SDB_203",   3'd2, 32'hA5,  32'h203,  21'h0,      32'h0,        0, 32'h203,      4'h8, 32'hA5A5A5A5, 32'h0,        2'b10, 2);
        vecs[2]  = mk("LDB_2",     3'd5, 32'h2,   32'h0,    21'h0,      32'h00800000, 0, 32'h2,        4'h0, 32'h0,        32'hFFFFFF80, 2'b01, 3);
        vecs[3]  = mk("LDBU_2",    3'd7, 32'h2,   32'h0,    21'h0,      32'h00800000, 0, 32'h2,        4'h0, 32'h0,        32'h00000080, 2'b01, 3);
        vecs[4]  = mk("LDH_mis",   3'd4, 32'h101, 32'h0,    21'h0,      32'h0,        1, 32'h0,        4'h0, 32'h0,        32'h0,        2'b00, 1);
        vecs[5]  = mk("OP110",     3'd6, 32'h0,   32'h0,    21'h0,      32'h0,        1, 32'h0,        4'h0, 32'h0,        32'h0,        2'b00, 1);
        vecs[6]  = mk("SDW_neg",   3'd0, 32'h12345678, 32'h1000, 21'h1FFFFC, 32'h0,   0, 32'hFFC,      4'hF, 32'h12345678, 32'h0,        2'b10, 2);
        vecs[7]  = mk("SDH_12",    3'd1, 32'hABCD1234, 32'h10, 21'h2,   32'h0,        0, 32'h12,       4'hC, 32'h12341234, 32'h0,        2'b10, 2);
        vecs[8]  = mk("LDH_22",    3'd4, 32'h20,  32'h0,    21'h2,      32'h80017FFF, 0, 32'h22,       4'h0, 32'h0,        32'hFFFF8001, 2'b01, 3);
        vecs[9]  = mk("LDW_mis",   3'd3, 32'h3,   32'h0,    21'h0,      32'h0,        1, 32'h0,        4'h0, 32'h0,        32'h0,        2'b00, 1);
        vecs[10] = mk("LDW_wrap",  3'd3, 32'h0,   32'h0,    21'h1FFFFC, 32'h11223344, 0, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h11223344, 2'b01, 3);
        vecs[11] = mk("LDB_3",     3'd5, 32'h3,   32'h0,    21'h0,      32'h7F000000, 0, 32'h3,        4'h0, 32'h0,        32'h0000007F, 2'b01, 3);
        vecs[12] = mk("SDH_mis",   3'd1, 32'h0,   32'h1,    21'h0,      32'h0,        1, 32'h0,        4'h0, 32'h0,        32'h0,        2'b00, 1);
        vecs[13] = mk("SDB_1",     3'd2, 32'hFF00, 32'h0,   21'h1,      32'h0,        0, 32'h1,        4'h2, 32'h00000000, 32'h0,        2'b10, 2);
        vecs[14] = mk("LDH_0",     3'd4, 32'h0,   32'h0,    21'h0,      32'h0000FFFE, 0, 32'h0,        4'h0, 32'h0,        32'hFFFFFFFE, 2'b01, 3);

        rst = 1'b1; en = 1'b0; opcode = 3'd0; xs = '0; xd = '0; imm = '0; mem_rdata = '0;
        ack_on = 1'b0; ack_delay = 0;
        en64 = 1'b0; opcode64 = 3'd0; xs64 = '0; xd64 = '0; imm64 = '0; mem_rdata64 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset mem_req", 64'(mem_req), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset y", 64'(y), 64'd0);
        chk("reset write_which", 64'(write_which), 64'd0);
        chk("reset mem_wstrb", 64'(mem_wstrb), 64'd0);

        foreach (vecs[i]) run_op(vecs[i], 0);
        run_op(vecs[0], 3);
        run_op(vecs[1], 2);

        // Timeout: no ack ever; mem_req must stay up exactly 15 cycles.
        @(negedge clk);
        ack_on = 1'b0; opcode = 3'd3; xs = 32'h40; imm = '0; en = 1'b1;
        req_hi = 0; done_cyc = -1; n_done = 0; n_err = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); @(negedge clk);
            if (mem_req) req_hi++;
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (err) n_err++;
        end
        en = 1'b0;
        chk("timeout req_cycles", 64'(req_hi), 64'd15);
        chk("timeout done_cycle", 64'(done_cyc), 64'd16);
        chk("timeout done_pulses", 64'(n_done), 64'd1);
        chk("timeout err_pulses", 64'(n_err), 64'd1);
        $display("txn timeout req_cycles=%0d done_cyc=%0d", req_hi, done_cyc);

        // Abort in REQ: en dropped before any ack.
        @(posedge clk); @(negedge clk);
        ack_on = 1'b0; opcode = 3'd3; xs = 32'h80; en = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("abort_req in_req", 64'(mem_req), 64'd1);
        en = 1'b0;
        n_done = 0; ww_or = 0; req_hi = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (done) n_done++;
            if (mem_req) req_hi++;
            ww_or = ww_or | write_which;
        end
        chk("abort_req mem_req", 64'(req_hi), 64'd0);
        chk("abort_req done", 64'(n_done), 64'd0);
        chk("abort_req write_which", 64'(ww_or), 64'd0);
        $display("txn abort_req done=%0d", n_done);

        // Abort in WB: en dropped during the write-back cycle.
        ack_on = 1'b1; ack_delay = 0; opcode = 3'd3; xs = 32'h84; mem_rdata = 32'h0BADF00D; en = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        en = 1'b0;
        #1;
        chk("abort_wb write_which", 64'(write_which), 64'd0);
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_wb done", 64'(n_done), 64'd0);
        $display("txn abort_wb done=%0d", n_done);

        // Reset while in REQ, with ack asserted in the reset cycle.
        ack_on = 1'b0; opcode = 3'd3; xs = 32'h88; mem_rdata = 32'h55AA55AA; en = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("rst_req in_req", 64'(mem_req), 64'd1);
        rst = 1'b1; ack_on = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_req mem_req", 64'(mem_req), 64'd0);
        chk("rst_req mem_we", 64'(mem_we), 64'd0);
        chk("rst_req write_which", 64'(write_which), 64'd0);
        chk("rst_req done_err", 64'({done, err}), 64'd0);
        chk("rst_req y", 64'(y), 64'd0);
        rst = 1'b0; en = 1'b0; ack_on = 1'b0;
        $display("txn rst_in_req y=%0h mem_req=%0d", y, mem_req);

        // 64-bit instance: SDH at lane 6, then LDW from the upper word.
        @(negedge clk);
        opcode64 = 3'd1; xd64 = 64'h6; xs64 = 64'h1234; imm64 = '0; en64 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("x64 SDH mem_req", 64'(mem_req64), 64'd1);
        chk("x64 SDH addr", mem_addr64, 64'h6);
        chk("x64 SDH wstrb", 64'(mem_wstrb64), 64'hC0);
        chk("x64 SDH wdata", mem_wdata64, 64'h1234123412341234);
        chk("x64 SDH write_which", 64'(ww64), 64'd2);
        @(posedge clk); @(negedge clk);
        chk("x64 SDH done", 64'(done64), 64'd1);
        $display("txn x64_SDH wstrb=%0h wdata=%0h", mem_wstrb64, mem_wdata64);
        en64 = 1'b0;
        @(posedge clk); @(negedge clk);
        opcode64 = 3'd3; xs64 = 64'h4; mem_rdata64 = 64'h80000000_00000000; en64 = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("x64 LDW write_which", 64'(ww64), 64'd1);
        chk("x64 LDW y", y64, 64'hFFFFFFFF_80000000);
        @(posedge clk); @(negedge clk);
        chk("x64 LDW done", 64'(done64), 64'd1);
        $display("txn x64_LDW y=%0h", y64);
        en64 = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data/address width; legal values are 32 and 64.
REQ-002 Parameter IMM_W, default 21, SHALL set the immediate width.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum wait cycles for mem_ack.
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports SHALL be as follows (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 en  in  1  operation request; held high until done is seen
 opcode  in  3  access type
 xs  in  XLEN  load base / store data
 xd  in  XLEN  store base
 imm  in  IMM_W  signed offset
 mem_req  out  1  memory request
 mem_we  out  1  1 = write
 mem_addr  out  XLEN  byte address
 mem_wdata  out  XLEN  write data, lane-replicated
 mem_wstrb  out  XLEN/8  byte enables
 mem_rdata  in  XLEN  read data
 mem_ack  in  1  memory accepted/returned
 y  out  XLEN  load result
 write_which  out  2  01 regfile, 10 memory, 00 none
 done  out  1  one-cycle completion pulse
 err  out  1  one-cycle error pulse, coincident with done

Function
REQ-006 Opcodes: 000 SDW, 001 SDH, 010 SDB, 011 LDW, 100 LDH, 101 LDB, 111 LDBU; 110 SHALL be illegal (err).
REQ-007 Address SHALL be base + sign-extended imm, modulo 2^XLEN; base is xd for stores, xs for loads.
REQ-008 FSM states SHALL be IDLE, REQ, WB, FIN.
REQ-009 IDLE -> REQ when en=1 and opcode legal and address aligned; otherwise IDLE -> FIN with err=1, mem_req never asserted.
REQ-010 Misalignment: W with addr[1:0]!=0, H with addr[0]!=0 SHALL be errors; B never misaligned.
REQ-011 In REQ, mem_req=1 with mem_addr/mem_we/mem_wdata/mem_wstrb stable until the cycle mem_ack=1.
REQ-012 mem_ack in REQ: store -> FIN with write_which=10 that cycle; load -> capture mem_rdata, go to WB.
REQ-013 Lane = addr[log2(XLEN/8)-1:0]; wstrb SHALL cover 4/2/1 bytes starting at that lane; wdata SHALL replicate xs[31:0]/[15:0]/[7:0] across all lanes.
REQ-014 Loads SHALL extract the lane; LDW/LDH/LDB sign-extend, LDBU zero-extends to XLEN.
REQ-015 WB SHALL drive y and write_which=01 for exactly one cycle, then go to FIN.
REQ-016 FIN SHALL assert done for exactly one cycle, then stay in FIN (done=0) until en=0, then IDLE.
REQ-017 If TIMEOUT consecutive REQ cycles elapse with no mem_ack, SHALL drop mem_req, go to FIN with err=1.
REQ-018 en deasserted in REQ or WB SHALL abort to IDLE next cycle, no done, no regfile write.
REQ-019 Minimum latency: store done 2 cycles after accept, load done 3 cycles after accept (zero-wait ack).
REQ-020 Outside REQ, mem_req=0; outside the stated cycles, write_which=00.

Reset
REQ-021 rst SHALL force IDLE and clear mem_req, mem_we, mem_wstrb, write_which, done, err, y, timeout counter, in any state, overriding mem_ack.

Structure
REQ-022 Opcode, write_which and state encodings SHALL live in shared package lsu_pkg.
REQ-023 Lane/strobe/extension logic SHALL be sub-module lsu_lane_align (combinational, XLEN-parametrised).

Verification
REQ-024 XLEN=32, LDW xs=0x100 imm=4, ack next cycle rdata=0xDEADBEEF -> mem_addr=0x104, y=0xDEADBEEF, write_which=01, done 3 cycles after accept.
REQ-025 SDB xd=0x203 imm=0 xs=0xA5 -> wstrb=1000, wdata=0xA5A5A5A5, write_which=10, done.
REQ-026 LDB addr 0x2 rdata=0x00800000 -> y=0xFFFFFF80; LDBU -> y=0x00000080.
REQ-027 LDH xs=0x101 -> err=1 and done=1, mem_req never high; opcode 110 -> same.
REQ-028 No ack for 15 cycles -> mem_req drops, err+done pulse; rst mid-REQ -> IDLE, all outputs cleared next cycle.
REQ-029 XLEN=64, SDH addr 0x6 xs=0x1234 -> wstrb=0xC0, wdata=0x1234 replicated in four halfword lanes.
